// File: rtl/bsg_sram_1rw_port_arb.sv
// Shares one 1RW SRAM macro between a write client and a read client, round-robin on contention.
// Read data lands in a 2-entry FIFO two cycles after accept; r_ready_o drops unless a FIFO slot is guaranteed.
module bsg_sram_1rw_port_arb #(
   parameter  int width_p       = 32,
   parameter  int els_p         = 8,
   localparam int addr_width_lp = $clog2(els_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,

   input  logic                     w_v_i,
   input  logic [addr_width_lp-1:0] w_addr_i,
   input  logic [width_p-1:0]       w_data_i,
   output logic                     w_ready_o,

   input  logic                     r_v_i,
   input  logic [addr_width_lp-1:0] r_addr_i,
   output logic                     r_ready_o,
   output logic [width_p-1:0]       r_data_o,
   output logic                     r_v_o,
   input  logic                     r_yumi_i,

   output logic                     sram_ce_o,
   output logic                     sram_we_o,
   output logic [addr_width_lp-1:0] sram_addr_o,
   output logic [width_p-1:0]       sram_wdata_o,
   output logic [width_p-1:0]       sram_wmask_o,
   input  logic [width_p-1:0]       sram_rdata_i
);

   logic                last_grant_r;
   logic                inflight_r;
   logic [1:0]          count_r;
   logic                head_r;
   logic                tail_r;
   logic [width_p-1:0]  fifo_mem_r [2];

   logic [2:0]          occupancy;
   logic                read_ok;
   logic                w_elig;
   logic                r_elig;
   logic                grant_w;
   logic                grant_r;
   logic                deq;

   // Occupancy counts the read still in the macro, so a granted read always finds a slot.
   always_comb begin
      occupancy = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, r_yumi_i};
      read_ok   = occupancy < 3'd2;
      w_elig    = reset_n_i & w_v_i;
      r_elig    = reset_n_i & r_v_i & read_ok;
      grant_w   = w_elig & (~r_elig | last_grant_r);
      grant_r   = r_elig & (~w_elig | ~last_grant_r);
   end

   assign w_ready_o    = grant_w;
   assign r_ready_o    = grant_r;
   assign sram_ce_o    = grant_w | grant_r;
   assign sram_we_o    = grant_w;
   assign sram_addr_o  = grant_r ? r_addr_i : w_addr_i;
   assign sram_wdata_o = w_data_i;
   assign sram_wmask_o = '0;

   assign r_v_o    = (count_r != 2'd0);
   assign r_data_o = fifo_mem_r[head_r];
   assign deq      = r_yumi_i & r_v_o;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         last_grant_r <= 1'b1;
         inflight_r   <= 1'b0;
         count_r      <= 2'd0;
         head_r       <= 1'b0;
         tail_r       <= 1'b0;
      end else begin
         if (grant_w) begin
            last_grant_r <= 1'b0;
         end else if (grant_r) begin
            last_grant_r <= 1'b1;
         end
         inflight_r <= grant_r;
         if (inflight_r) begin
            tail_r <= ~tail_r;
         end
         if (deq) begin
            head_r <= ~head_r;
         end
         if (inflight_r && !deq) begin
            count_r <= count_r + 2'd1;
         end else if (!inflight_r && deq) begin
            count_r <= count_r - 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (inflight_r) begin
         fifo_mem_r[tail_r] <= sram_rdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!(r_yumi_i && !r_v_o))
            else $error("r_yumi_i asserted while read FIFO is empty");
      end
   end

endmodule

// File: tb/tb_bsg_sram_1rw_port_arb.sv
// Bench for bsg_sram_1rw_port_arb: directed scenarios plus a queue-based reference model checked every cycle.
module tb_bsg_sram_1rw_port_arb;
   localparam int W = 32;
   localparam int A = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic          w_v, r_v, yumi_en;
   logic [A-1:0]  w_addr, r_addr;
   logic [W-1:0]  w_data;
   logic          w_ready, r_ready, r_v_o, sram_ce, sram_we, r_yumi;
   logic [W-1:0]  r_data, sram_wdata, sram_wmask, sram_rdata;
   logic [A-1:0]  sram_addr;

   assign r_yumi = yumi_en & r_v_o;

   bsg_sram_1rw_port_arb #(.width_p(W), .els_p(8)) dut (
      .clk_i       (clk),
      .reset_n_i   (reset_n),
      .w_v_i       (w_v),
      .w_addr_i    (w_addr),
      .w_data_i    (w_data),
      .w_ready_o   (w_ready),
      .r_v_i       (r_v),
      .r_addr_i    (r_addr),
      .r_ready_o   (r_ready),
      .r_data_o    (r_data),
      .r_v_o       (r_v_o),
      .r_yumi_i    (r_yumi),
      .sram_ce_o   (sram_ce),
      .sram_we_o   (sram_we),
      .sram_addr_o (sram_addr),
      .sram_wdata_o(sram_wdata),
      .sram_wmask_o(sram_wmask),
      .sram_rdata_i(sram_rdata)
   );

   // Single-port synchronous macro
   logic [W-1:0] sram_mem [8];
   always @(posedge clk) begin
      if (sram_ce && sram_we) sram_mem[sram_addr] <= sram_wdata;
      if (sram_ce && !sram_we) sram_rdata <= sram_mem[sram_addr];
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: accepted-but-unconsumed reads in a queue, tagged with accept cycle
   typedef struct {
      logic [W-1:0] dat;
      int           cyc;
   } rd_t;

   rd_t          q[$];
   logic [W-1:0] mem_ref [8];
   int           cyc;
   bit           last_rd;

   initial begin
      for (int i = 0; i < 8; i++) mem_ref[i] = '0;
      cyc     = 0;
      last_rd = 1'b1;
      forever begin
         @(negedge clk);
         begin : model_step
            int occ;
            bit r_el, gw, gr, exp_rv;
            if (!reset_n) begin
               check("rst_w_ready", w_ready, 0);
               check("rst_r_ready", r_ready, 0);
               check("rst_ce", sram_ce, 0);
               check("rst_we", sram_we, 0);
               check("rst_r_v", r_v_o, 0);
               q.delete();
               last_rd = 1'b1;
            end else begin
               occ  = q.size() - (r_yumi ? 1 : 0);
               r_el = r_v && (occ < 2);
               if (w_v && r_el) begin
                  gw = last_rd;
                  gr = !last_rd;
               end else begin
                  gw = w_v;
                  gr = r_el;
               end
               exp_rv = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
               check("m_w_ready", w_ready, gw);
               check("m_r_ready", r_ready, gr);
               check("m_ce", sram_ce, gw | gr);
               check("m_we", sram_we, gw);
               check("m_addr", sram_addr, gr ? r_addr : w_addr);
               check("m_wdata", sram_wdata, w_data);
               check("m_wmask", sram_wmask, 0);
               check("m_r_v", r_v_o, exp_rv);
               if (exp_rv) check("m_r_data", r_data, q[0].dat);
               if (r_yumi && q.size() > 0) void'(q.pop_front());
               if (w_v && w_ready) begin
                  mem_ref[w_addr] = w_data;
                  last_rd = 1'b0;
               end
               if (r_v && r_ready) begin
                  q.push_back('{dat: mem_ref[r_addr], cyc: cyc});
                  last_rd = 1'b1;
               end
               check("m_occupancy_le2", q.size() <= 2, 1);
            end
            cyc++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      w_v = 0; r_v = 0;
   endtask

   initial begin
      reset_n = 0; w_v = 0; r_v = 0; yumi_en = 0;
      w_addr = '0; r_addr = '0; w_data = '0;
      for (int i = 0; i < 8; i++) sram_mem[i] = '0;
      tick();
      #3;
      check("reset_r_v", r_v_o, 0);
      check("reset_ce", sram_ce, 0);
      tick(); tick();
      reset_n = 1;

      // Write then read-after-write to addr 3
      w_v = 1; w_addr = 3'd3; w_data = 32'hDEADBEEF; yumi_en = 1;
      #3; check("t1_w_ready_c0", w_ready, 1);
      tick();
      w_v = 0; r_v = 1; r_addr = 3'd3;
      #3; check("t1_r_ready_c1", r_ready, 1);
      tick();
      r_v = 0;
      #3; check("t1_r_v_c2", r_v_o, 0);
      tick();
      #3;
      check("t1_r_v_c3", r_v_o, 1);
      check("t1_r_data_c3", r_data, 32'hDEADBEEF);
      tick();

      // Contention: alternate W,R starting with W
      for (int i = 0; i < 8; i++) begin
         w_v = 1; r_v = 1;
         w_addr = 3'(i / 2); r_addr = 3'(i / 2); w_data = 32'(256 + i / 2);
         #3;
         check("t2_w_ready", w_ready, (i % 2) == 0);
         check("t2_r_ready", r_ready, (i % 2) == 1);
         check("t2_ce", sram_ce, 1);
         tick();
      end
      idle();
      repeat (3) tick();

      // Fill 0..7 then stream 8 reads
      for (int i = 0; i < 8; i++) begin
         w_v = 1; w_addr = 3'(i); w_data = 32'(i);
         #3; check("t3_w_ready", w_ready, 1);
         tick();
      end
      w_v = 0;
      for (int i = 0; i < 11; i++) begin
         r_v = (i < 8); r_addr = 3'(i);
         #3;
         if (i < 8) check("t3_r_ready", r_ready, 1);
         if (i >= 2 && i < 10) begin
            check("t3_r_v", r_v_o, 1);
            check("t3_r_data", r_data, 32'(i - 2));
         end
         if (i == 10) check("t3_r_v_end", r_v_o, 0);
         tick();
      end

      // Backpressure: FIFO fills, writes still flow
      yumi_en = 0;
      for (int i = 0; i < 5; i++) begin
         r_v = 1; r_addr = (i == 0) ? 3'd5 : ((i == 1) ? 3'd6 : 3'd0);
         w_v = (i == 3); w_addr = 3'd7; w_data = 32'h77;
         #3;
         check("t4_r_ready", r_ready, i < 2);
         if (i == 3) check("t4_w_ready", w_ready, 1);
         if (i == 4) check("t4_full_r_v", r_v_o, 1);
         tick();
      end
      w_v = 0; r_v = 1; r_addr = 3'd2; yumi_en = 1;
      #3;
      check("t4_reenable", r_ready, 1);
      check("t4_head0", r_data, 32'd5);
      tick();
      r_v = 0;
      #3; check("t4_head1", r_data, 32'd6);
      tick();
      #3; check("t4_head2", r_data, 32'd2);
      tick();
      #3; check("t4_empty", r_v_o, 0);
      tick();

      // Reset with one entry buffered and one read in flight
      yumi_en = 0; r_v = 1; r_addr = 3'd1;
      #3; check("t5_acc0", r_ready, 1);
      tick();
      r_v = 0;
      tick();
      r_v = 1; r_addr = 3'd2;
      #3;
      check("t5_pre_r_v", r_v_o, 1);
      check("t5_acc1", r_ready, 1);
      tick();
      reset_n = 0; w_v = 1; r_v = 1;
      #1; check("t5_rst_r_v", r_v_o, 0);
      for (int i = 0; i < 3; i++) begin
         #2;
         check("t5_rst_ce", sram_ce, 0);
         check("t5_rst_w_ready", w_ready, 0);
         tick();
      end
      reset_n = 1; idle(); yumi_en = 1;
      for (int i = 0; i < 5; i++) begin
         #3; check("t5_no_stale", r_v_o, 0);
         tick();
      end

      // Random traffic, checked by the model
      for (int i = 0; i < 400; i++) begin
         w_v     = 1'($urandom_range(0, 1));
         r_v     = 1'($urandom_range(0, 1));
         yumi_en = 1'($urandom_range(0, 3) != 0);
         w_addr  = 3'($urandom_range(0, 7));
         r_addr  = 3'($urandom_range(0, 7));
         w_data  = $urandom;
         tick();
      end
      idle(); yumi_en = 1;
      repeat (5) tick();
      #3;
      check("final_r_v", r_v_o, 0);
      check("final_model_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bsg_sram_1rw_port_arb.md
# bsg_sram_1rw_port_arb

Sequencer that shares one single-port synchronous SRAM macro (32-bit × 8 entries, one shared address, write-enable and chip-enable) between an independent write requester and a read requester. It presents the 1r1w client view with valid/ready handshakes and round-robin arbitration. Read data is returned through a 2-entry output FIFO with valid/yumi flow control. It sits between the cache/DMA logic and the SRAM macro, in place of a direct macro hookup.

## Interface
- width_p, 32, data width of SRAM and client ports
- els_p, 8, SRAM depth; addr_width = ceil(log2(els_p)) = 3
- clk_i  in  1  single clock; SRAM macro clocked by the same net
- reset_n_i  in  1  asynchronous, active-low reset
- w_v_i  in  1  write request valid
- w_addr_i  in  addr_width  write address
- w_data_i  in  width_p  write data
- w_ready_o  out  1  write accepted this cycle (w_v_i & w_ready_o)
- r_v_i  in  1  read request valid
- r_addr_i  in  addr_width  read address
- r_ready_o  out  1  read accepted this cycle
- r_data_o  out  width_p  head of read-data FIFO
- r_v_o  out  1  r_data_o valid
- r_yumi_i  in  1  consumer takes r_data_o; legal only when r_v_o=1
- sram_ce_o  out  1  macro chip enable
- sram_we_o  out  1  macro write enable (1=write)
- sram_addr_o  out  addr_width  macro shared address
- sram_wdata_o  out  width_p  macro write data
- sram_wmask_o  out  width_p  macro write mask; constant all-zero (full-word write)
- sram_rdata_i  in  width_p  macro read data, valid the cycle after a read issue

## Operation
- State: last_grant_r (0=write, 1=read), inflight_r (a read was issued last cycle), 2-entry FIFO with count_r ∈ {0,1,2}, head pointer, and tail pointer.
- read_ok = (count_r + inflight_r − r_yumi_i) < 2, computed at 3-bit width. This guarantees every issued read has a FIFO slot when its data returns.
- Arbitration, combinational, per cycle:
  - Only w_v_i: grant write.
  - Only r_v_i with read_ok: grant read.
  - Both eligible: grant the side not equal to last_grant_r.
  - r_v_i with read_ok=0: the read is not eligible. A write may take the port.
- last_grant_r updates only when a grant occurs.
- Write grant: w_ready_o=1, sram_ce_o=1, sram_we_o=1, sram_addr_o=w_addr_i, sram_wdata_o=w_data_i.
- Read grant: r_ready_o=1, sram_ce_o=1, sram_we_o=0, sram_addr_o=r_addr_i. inflight_r is set for the next cycle.
- No grant: sram_ce_o=0 and sram_we_o=0. sram_addr_o and sram_wdata_o are don't-care but held stable at the write inputs.
- At most one SRAM operation per cycle. Read-after-write to the same address in consecutive cycles returns the new data, because the macro is single-port and the operations are serialised.
- When inflight_r=1, sram_rdata_i is enqueued at the tail on that clock edge.
- r_yumi_i dequeues the head. Simultaneous enqueue and dequeue leaves count_r unchanged.
- Ready outputs depend combinationally on the valids and on r_yumi_i. Valids must not depend on readies.

## Timing
- Reset (async assert, sync deassert at the block's reset synchroniser): count_r=0, inflight_r=0, last_grant_r=1 (first contention goes to write), r_v_o=0.
- While reset_n_i=0: w_ready_o=0, r_ready_o=0, sram_ce_o=0, sram_we_o=0.
- Reset asserted mid-operation discards any in-flight read and all FIFO contents. No r_v_o for them after release.
- Write latency: write visible in the macro at the accept edge. A read accepted in the next cycle sees it.
- Read latency: accept at cycle t, data in the FIFO at end of t+1, r_v_o=1 from cycle t+2.
- Sustained throughput: one read per cycle with r_yumi_i held high. Alternating 1:1 under contention.
- FIFO full (count_r=2, no yumi): r_ready_o=0. Writes continue unaffected.
- Pointers wrap modulo 2.
- r_yumi_i with r_v_o=0 is illegal; an assertion fires.

## Test plan
- Reset, then write 0xDEADBEEF to addr 3, then read addr 3 the next cycle → w_ready_o=1 at cycle 0; r_ready_o=1 at cycle 1; r_v_o=1 with r_data_o=0xDEADBEEF at cycle 3.
- w_v_i and r_v_i both held high for 8 cycles, r_yumi_i=1 → grants alternate W,R,W,R… starting with W; 4 writes and 4 reads; sram_ce_o=1 every cycle.
- Fill addr 0..7 with value=addr, then 8 back-to-back reads with yumi always 1 → r_v_o high for 8 consecutive cycles starting 2 cycles after the first accept, data 0..7 in order.
- Reads with r_yumi_i=0 → exactly 2 reads accepted, then r_ready_o=0. A concurrent write is still accepted. Raising yumi drains 2 entries and re-enables reads.
- Assert reset_n_i=0 one cycle after a read accept with count_r=1 → r_v_o=0 immediately; after release, no stale data appears; sram_ce_o=0 throughout reset.
- Randomised valid/yumi traffic against a reference array model → all read data match, and FIFO occupancy never exceeds 2.
